adc_sample_capture: RTL and testbench
=====================================

# adc_sample_capture

Acquisition front end feeding the USB/FT245 transfer controller. On a one-cycle start pulse it generates the ADC sample clock from the system clock, drops the converter's pipeline warm-up samples, writes a fixed-length burst of 12-bit samples into an internal 1024×16 buffer, and pulses done. The downstream controller then reads the buffer by address and streams each word out as two bytes.

## Interface
- DEPTH, 1024, samples stored per capture; address wraps at DEPTH.
- ADDR_WIDTH, 10, buffer address width (log2 DEPTH).
- DIV_WIDTH, 11, width of the divider input.
- PIPE_DISCARD, 8, ADC clock rising edges discarded after start (converter pipeline latency).

- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-low reset.
- SART_TURN  in  1  start pulse, one CLK wide.
- DIVIDER  in  DIV_WIDTH  ADC_CLK half-period minus one, in CLK cycles.
- ADC_BIT  in  12  converter data, offset binary.
- ADC_OTR  in  1  converter out-of-range flag.
- ADC_CLK  out  1  converter sample clock.
- ADC_OE  out  1  converter output enable, active low.
- RAM_RD_ADDR  in  ADDR_WIDTH  buffer read address.
- RAM_DATA_OUT  out  16  buffer read data, asynchronous read.
- TURN_DONE  out  1  one-CLK pulse when a capture completes.

## Operation
- **Input registers:** ADC_BIT and ADC_OTR are registered every CLK into adc_q and otr_q. Only the registered values are stored.
- **Stored word:** {3'b000, 1'b0, adc_q[11:0]}. Bit 12 is governed by the Configuration section.
- **State machine:** IDLE → WARMUP → CAPTURE → DONE → IDLE.
  - **IDLE:** ADC_CLK=0, ADC_OE=1, divider counter cleared. SART_TURN=1 latches DIVIDER into div_q, clears the sample counter, and enters WARMUP.
  - **WARMUP / CAPTURE:** ADC_OE=0. The half-period counter counts 0..div_q; ADC_CLK toggles on wrap.
    - A "rise event" is the CLK cycle that drives ADC_CLK 0→1.
    - In WARMUP, rise events increment the discard counter. After PIPE_DISCARD events, go to CAPTURE. With PIPE_DISCARD=0, go straight to CAPTURE.
    - In CAPTURE, each rise event writes the stored word to buffer[wr_addr] and increments wr_addr.
    - The write at wr_addr=DEPTH-1 enters DONE.
  - **DONE:** one cycle. TURN_DONE=1, ADC_CLK forced 0, ADC_OE=1, then IDLE.
- SART_TURN outside IDLE is ignored; no queuing.
- DIVIDER changes outside IDLE have no effect until the next start (div_q is used).
- DIVIDER=0 gives ADC_CLK = CLK/2, the maximum rate.
- **Buffer:** inferred distributed RAM, one write port and one asynchronous read port. RAM_DATA_OUT = buffer[RAM_RD_ADDR] combinationally.
  - A read of the address being written returns the new word from the cycle after the write.
  - Buffer contents are not cleared by reset or start. Unwritten locations are undefined.

## Timing
- **Reset values:** ADC_CLK=0, ADC_OE=1, TURN_DONE=0, state IDLE, all counters 0. Reset acts immediately and asynchronously, including mid-capture. Any partial buffer contents are left as they are.
- **Start timing (start sampled at cycle 0):**
  - State WARMUP and ADC_OE=0 from cycle 1.
  - First rise event at cycle 1+div_q+1.
- **Steady state:**
  - ADC_CLK period = 2·(div_q+1) CLK cycles, 50 % duty.
  - Rise event n (n from 0) occurs at cycle (div_q+1)·(2n+1)+1.
- **Sample alignment:** the stored sample is adc_q at the rise-event cycle, i.e. ADC_BIT as sampled one CLK earlier. This is the value held before the new ADC_CLK edge.
- **Completion:**
  - Total rise events per capture = PIPE_DISCARD+DEPTH.
  - TURN_DONE is high for exactly one cycle: the cycle after the final write.
  - A new start is accepted from the cycle after TURN_DONE.
- **Counter widths:**
  - wr_addr is ADDR_WIDTH bits; the terminal compare is against DEPTH-1, and the address never overflows within a capture.
  - The discard counter is sized to hold PIPE_DISCARD.

## Configuration
- **ADC_CAPTURE_OTR_EN**
  - Defined: stored bit 12 = otr_q at the rise event, so out-of-range samples are flagged per word.
  - Undefined: bit 12 = 0, ADC_OTR is unused, and the otr_q register is not built.
- In both cases bits 15:13 = 0.

## Test plan
- **Reset values:** assert RST=0 mid-run, then release → ADC_CLK=0, ADC_OE=1, TURN_DONE=0 immediately. No ADC_CLK edges until a start.
- **Maximum rate:** DIVIDER=0, ADC_BIT ramps +1 per ADC_CLK rise starting at 0x000, start pulse →
  - ADC_CLK period 2 cycles and 1032 rises total.
  - buffer[k] equals the ramp value that preceded rise 8+k.
  - TURN_DONE is a single pulse.
- **Divided rate:** DIVIDER=3 → ADC_CLK period 8 cycles, first rise at cycle 5 after start. TURN_DONE once, after 1032 rises.
- **Ignored inputs while busy:** SART_TURN pulsed and DIVIDER changed to 9 during CAPTURE → period stays 8, no restart, single TURN_DONE.
- **Reset mid-capture:** RST low at rise 500 → outputs return to reset values and no TURN_DONE. A following start completes normally.
- **OTR flag:** ADC_OTR=1 for one ADC_CLK period around capture 5 →
  - with ADC_CAPTURE_OTR_EN: buffer[5][12]=1, all others 0.
  - without: every bit 12 = 0.

Source files
------------

// File: rtl/adc_sample_capture.sv
// ADC acquisition front end: generates ADC_CLK, drops pipeline warm-up samples and
// captures DEPTH words into a distributed RAM. Optional macro: ADC_CAPTURE_OTR_EN.
module adc_sample_capture #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int DIV_WIDTH    = 11,
  parameter int PIPE_DISCARD = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SART_TURN,
  input  logic [DIV_WIDTH-1:0]  DIVIDER,
  input  logic [11:0]           ADC_BIT,
  input  logic                  ADC_OTR,
  output logic                  ADC_CLK,
  output logic                  ADC_OE,
  input  logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  output logic [15:0]           RAM_DATA_OUT,
  output logic                  TURN_DONE
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WARMUP  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int DISC_W = (PIPE_DISCARD > 0) ? $clog2(PIPE_DISCARD + 1) : 1;
  localparam logic [DISC_W-1:0]     DISC_LAST = DISC_W'((PIPE_DISCARD > 0) ? PIPE_DISCARD - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0] FIRST_ACTIVE = (PIPE_DISCARD == 0) ? CAPTURE : WARMUP;

  logic [1:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  adc_clk_q, adc_clk_d;
  logic                  rise_q, rise_d;
  logic [DISC_W-1:0]     disc_q, disc_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]           adc_q;
  logic                  wr_en;
  logic                  wrap;
  logic                  busy;
  logic [15:0]           wr_word;
  logic [15:0]           mem [DEPTH];

`ifdef ADC_CAPTURE_OTR_EN
  logic otr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) otr_q <= 1'b0;
    else      otr_q <= ADC_OTR;
  end

  assign wr_word = {3'b000, otr_q, adc_q};
`else
  logic unused_otr;
  assign unused_otr = ADC_OTR;
  assign wr_word    = {4'b0000, adc_q};
`endif

  assign wrap = (cnt_q == div_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    adc_clk_d = adc_clk_q;
    rise_d    = 1'b0;
    disc_d    = disc_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        adc_clk_d = 1'b0;
        if (SART_TURN) begin
          div_d     = DIVIDER;
          wr_addr_d = '0;
          disc_d    = '0;
          state_d   = FIRST_ACTIVE;
        end
      end
      WARMUP, CAPTURE: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          adc_clk_d = ~adc_clk_q;
          rise_d    = ~adc_clk_q;
        end
        // rise_q marks the cycle in which ADC_CLK is first seen high; adc_q still
        // holds the converter word presented before that edge.
        if (rise_q) begin
          if (state_q == WARMUP) begin
            if (disc_q == DISC_LAST) state_d = CAPTURE;
            else                     disc_d  = disc_q + 1'b1;
          end else begin
            wr_en = 1'b1;
            if (wr_addr_q == ADDR_LAST) state_d   = DONE;
            else                        wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d     = '0;
        adc_clk_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      disc_q    <= '0;
      wr_addr_q <= '0;
      adc_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
      rise_q    <= rise_d;
      disc_q    <= disc_d;
      wr_addr_q <= wr_addr_d;
      adc_q     <= ADC_BIT;
    end
  end

  // NOTE: the sample buffer has no reset; clearing it would prevent distributed-RAM inference.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr_q] <= wr_word;
  end

  assign RAM_DATA_OUT = mem[RAM_RD_ADDR];

  assign busy      = (state_q == WARMUP) || (state_q == CAPTURE);
  assign ADC_OE    = ~busy;
  assign ADC_CLK   = adc_clk_q & busy;
  assign TURN_DONE = (state_q == DONE);

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed self-checking bench for adc_sample_capture: rates, busy-input immunity,
// mid-capture reset and the optional OTR flag bit.
module tb_adc_sample_capture;

  localparam int TOTAL_RISES = 8 + 1024;

`ifdef ADC_CAPTURE_OTR_EN
  localparam bit OTR_EXP = 1'b1;
`else
  localparam bit OTR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sart_turn;
  logic [10:0] divider;
  logic [11:0] adc_bit;
  logic        adc_otr;
  logic        adc_clk;
  logic        adc_oe;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        turn_done;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor-owned counters, sampled 1 ns after every rising CLK edge.
  int  edge_cnt = 0;
  int  rises = 0;
  int  done_cnt = 0;
  int  first_rise_edge = 0;
  int  last_rise_edge = 0;
  int  done_edge = 0;
  int  pmin = 1000000;
  int  pmax = 0;
  logic clk_prev = 1'b0;
  logic clr_req = 1'b0;
  int  start_edge = 0;

  adc_sample_capture dut (
    .CLK          (clk),
    .RST          (rst_n),
    .SART_TURN    (sart_turn),
    .DIVIDER      (divider),
    .ADC_BIT      (adc_bit),
    .ADC_OTR      (adc_otr),
    .ADC_CLK      (adc_clk),
    .ADC_OE       (adc_oe),
    .RAM_RD_ADDR  (rd_addr),
    .RAM_DATA_OUT (rd_data),
    .TURN_DONE    (turn_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The converter ramps by one after every ADC_CLK rise; OTR is flagged for the
  // period that precedes rise 13 (capture index 5).
  assign adc_bit = 12'(rises);
  assign adc_otr = (rises == 13);

  always @(posedge clk) begin
    #1;
    edge_cnt = edge_cnt + 1;
    if (clr_req) begin
      rises    = 0;
      done_cnt = 0;
      pmin     = 1000000;
      pmax     = 0;
    end
    if (adc_clk && !clk_prev) begin
      if (rises > 0) begin
        if (edge_cnt - last_rise_edge < pmin) pmin = edge_cnt - last_rise_edge;
        if (edge_cnt - last_rise_edge > pmax) pmax = edge_cnt - last_rise_edge;
      end else begin
        first_rise_edge = edge_cnt;
      end
      last_rise_edge = edge_cnt;
      rises = rises + 1;
    end
    clk_prev = adc_clk;
    if (turn_done) begin
      done_cnt  = done_cnt + 1;
      done_edge = edge_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expected_word(input int k);
    logic [15:0] w;
    w = 16'((8 + k) & 12'hFFF);
    if (k == 5) w[12] = OTR_EXP;
    return w;
  endfunction

  task automatic start_capture(input logic [10:0] div);
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    divider   = div;
    sart_turn = 1'b1;
    @(negedge clk) sart_turn = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_capture(input string tag, input int div);
    check({tag, "_first_rise_cycle"}, first_rise_edge - start_edge + 1, div + 2);
    check({tag, "_period_min"}, pmin, 2 * (div + 1));
    check({tag, "_period_max"}, pmax, 2 * (div + 1));
    check({tag, "_rises"}, rises, TOTAL_RISES);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_after_last_write"}, done_edge - last_rise_edge, 1);
    check({tag, "_idle_oe"}, adc_oe, 1);
    check({tag, "_idle_clk"}, adc_clk, 0);
  endtask

  task automatic check_buffer(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      rd_addr = 10'(k);
      #1;
      if (rd_data !== expected_word(k)) bad = bad + 1;
    end
    check({tag, "_buf_bad_words"}, bad, 0);
    rd_addr = 10'd0;    #1; check({tag, "_buf0"},    rd_data, 16'h0008);
    rd_addr = 10'd5;    #1; check({tag, "_buf5"},    rd_data, {3'b000, OTR_EXP, 12'h00D});
    rd_addr = 10'd1023; #1; check({tag, "_buf1023"}, rd_data, 16'h0407);
  endtask

  initial begin
    rst_n     = 1'b1;
    sart_turn = 1'b0;
    divider   = 11'd0;
    rd_addr   = 10'd0;

    // Reset values, then no ADC_CLK activity without a start.
    #2 rst_n = 1'b0;
    #1;
    check("reset_clk", adc_clk, 0);
    check("reset_oe", adc_oe, 1);
    check("reset_done", turn_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_rises", rises, 0);
    check("idle_oe", adc_oe, 1);

    // Maximum rate with ramp data and the OTR marker.
    start_capture(11'd0);
    check("max_oe_active", adc_oe, 0);
    wait_done("max", TOTAL_RISES * 2 + 100);
    check_capture("max", 0);
    check_buffer("max");

    // Divided rate; mid-capture start pulse and DIVIDER change must be ignored.
    start_capture(11'd3);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rises >= 200) break;
    end
    check("div_reached_capture", 32'(rises >= 200), 1);
    sart_turn = 1'b1;
    divider   = 11'd9;
    @(negedge clk) sart_turn = 1'b0;
    wait_done("div", TOTAL_RISES * 8 + 100);
    check_capture("div", 3);
    check_buffer("div");

    // Reset asserted mid-capture at rise 500.
    start_capture(11'd0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rises >= 500) break;
    end
    check("rst_reached_500", rises, 500);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk", adc_clk, 0);
    check("rst_mid_oe", adc_oe, 1);
    check("rst_mid_done", turn_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_more_rises", rises, 500);
    check("rst_no_done", done_cnt, 0);
    check("rst_oe_idle", adc_oe, 1);

    // A following start completes normally.
    start_capture(11'd0);
    wait_done("rerun", TOTAL_RISES * 2 + 100);
    check_capture("rerun", 0);
    check_buffer("rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
